matrix_fb_scan: RTL and testbench
=================================

Name: matrix_fb_scan

Overview:
Wishbone pipelined slave that holds the 8x8 picture written by the bus master: 8 rows, 32 bits per row, 4-bit intensity per pixel. It scans the LED matrix one row at a time. Each row's columns are driven with 16-level PWM. This is the consumer that sits directly downstream of the picture-loading bus master, and its outputs go straight to the matrix row and column drivers.

Parameters:
WB_DATA_WIDTH, 32, bus data width; must equal 4*8.
REG_COUNT, 8, number of row registers, which is also the number of matrix rows.
WB_ADDR_WIDTH, $clog2(REG_COUNT), register address width.
WB_SEL_WIDTH, WB_DATA_WIDTH/8, byte-select width.
CLK_DIV, 16, clk cycles per PWM tick; must be 2 or more.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  WB_ADDR_WIDTH  row register index
i_wb_sel  in  WB_SEL_WIDTH  byte lanes
i_wb_wdata  in  WB_DATA_WIDTH  row data; nibble c ([4c+3:4c]) is the intensity of column c
o_wb_ack  out  1  transfer acknowledge
o_wb_stall  out  1  always 0
o_wb_rdata  out  WB_DATA_WIDTH  read data
o_row  out  REG_COUNT  one-hot active-high row select
o_col  out  8  active-high column drive
o_frame  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset:
  - All row registers are 0 (dark).
  - o_wb_ack=0, o_wb_rdata=0, o_row=0, o_col=0, o_frame=0.
  - Internal counters are 0.
  - Reset mid-transfer drops any pending ack.
- Bus, pipelined, never stalls:
  - o_wb_stall is tied 0.
  - A request is i_wb_cyc && i_wb_stb.
  - Registered ack: the request at edge N gives ack high during cycle N+1.
  - o_wb_ack = r_ack && i_wb_cyc, so if the master drops cyc the ack is suppressed.
  - Back-to-back requests give back-to-back acks, one per request, in order.
- Writes:
  - Byte lanes with i_wb_sel[b]=1 update bits [8b+7:8b] of register i_wb_addr at the request edge.
  - Lanes with sel=0 are unchanged.
- Reads:
  - o_wb_rdata is registered alongside the ack and holds the register value at the request edge.
  - o_wb_rdata holds its value when there is no read.
- Scan counters:
  - tick_cnt runs 0..CLK_DIV-1 and wraps. tick is asserted when tick_cnt==CLK_DIV-1.
  - pwm_cnt (4 bits) increments on tick and wraps 15->0.
  - row_idx increments on tick when pwm_cnt==15, and wraps REG_COUNT-1 -> 0.
  - Row period is 16*CLK_DIV cycles. Frame period is REG_COUNT*16*CLK_DIV cycles.
- Outputs, registered, one cycle after the counters:
  - o_row = 1<<row_idx.
  - o_col[c] = (pix(row_idx,c) > pwm_cnt).
  - Duty is value/16. Value 0 is never lit. Value 15 is lit in slots 0..14.
  - Slot 15 is always dark. This gives built-in blanking before every row change, which avoids ghosting.
- o_frame pulses for one cycle, the cycle when o_row becomes row 0 (after reset release and every wrap).
- Write/scan collision:
  - A write to the row currently displayed takes effect on o_col at most 2 cycles after the request edge.
  - Tearing within a frame is permitted in single-buffer mode.
- First cycle after reset release: o_row=0 and o_col=0. On the next cycle o_row=1 and o_frame=1.

Optional Feature:
MATRIX_FB_DBUF_EN
- Defined:
  - Bus writes and reads target a back bank.
  - The scanner displays a front bank.
  - Any write sets a dirty flag.
  - Front and back swap, with the back bank copied into the front, in one cycle at the frame-end tick (row_idx==REG_COUNT-1, pwm_cnt==15, tick). The swap happens only when dirty==1 and i_wb_cyc==0; dirty is then cleared.
  - If cyc is high at that point, the swap is deferred to the next frame end.
  - Reset clears both banks and the dirty flag.
- Undefined: single bank; writes are visible immediately as described above.

Test Plan:
- Reset, then idle 2 frames with CLK_DIV=4 -> o_col==0 throughout; o_row cycles 01,02,..,80 every 64 cycles; o_frame pulses every 512 cycles.
- Write addr 0 = 32'hF0000000, sel=4'hF -> ack exactly 1 cycle later. In row 0, o_col[7] is high for 15 of 16 ticks and low in slot 15. Other columns stay 0.
- Write addr 3 = 32'h00000008, then read addr 3 back-to-back -> two consecutive acks; read data = 32'h00000008; row 3 col 0 duty = 8/16.
- Partial write: addr 2 = FFFFFFFF, then sel=4'b0010 with wdata 0 -> readback = 32'hFFFF00FF.
- Strobe with cyc dropped the next cycle -> o_wb_ack stays 0; reset asserted with an ack pending -> ack 0, all outputs 0.
- With DBUF_EN: write row 0 = 32'h11111111 mid-frame -> display unchanged until frame end, then updated. Hold cyc high across frame end -> swap delayed by one frame.

Source files
------------

// File: rtl/matrix_fb_scan_if.sv
// Wishbone pipelined bus bundle for the matrix framebuffer slave.
// Signal names keep the slave-side i_/o_ direction prefixes.
interface matrix_fb_scan_if #(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WB_ADDR_WIDTH = 3,
  parameter int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
);
  logic                     i_wb_cyc;
  logic                     i_wb_stb;
  logic                     i_wb_we;
  logic [WB_ADDR_WIDTH-1:0] i_wb_addr;
  logic [WB_SEL_WIDTH-1:0]  i_wb_sel;
  logic [WB_DATA_WIDTH-1:0] i_wb_wdata;
  logic                     o_wb_ack;
  logic                     o_wb_stall;
  logic [WB_DATA_WIDTH-1:0] o_wb_rdata;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_wdata,
    input  o_wb_ack, o_wb_stall, o_wb_rdata
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_wdata,
    output o_wb_ack, o_wb_stall, o_wb_rdata
  );
endinterface

// File: rtl/matrix_fb_scan.sv
// Wishbone framebuffer slave scanning an 8x8 LED matrix row by row with 16-level PWM.
// Define MATRIX_FB_DBUF_EN for a front/back bank pair swapped at frame end.
module matrix_fb_scan #(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT     = 8,
  parameter int unsigned WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
  parameter int unsigned CLK_DIV       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_fb_scan_if.slave      wb,
  output logic [REG_COUNT-1:0] o_row,
  output logic [7:0]           o_col,
  output logic                 o_frame
);
  localparam int unsigned NUM_COLS = 8;
  localparam int unsigned PIX_W    = 4;
  localparam int unsigned TICK_W   = $clog2(CLK_DIV);
  localparam int unsigned ROW_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(REG_COUNT - 1);
  localparam logic [PIX_W-1:0]  PWM_LAST  = '1;

  typedef logic [WB_DATA_WIDTH-1:0] word_t;

  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [PIX_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [ROW_W-1:0]     row_idx_q, row_idx_d;
  logic                 tick, row_adv;

  word_t                bank_q [REG_COUNT];
  word_t                bank_d [REG_COUNT];
  word_t                disp_row;

  logic                 req, wr_req, rd_req, addr_ok;
  logic                 ack_q, ack_d;
  word_t                rdata_q, rdata_d;

  logic [REG_COUNT-1:0] row_q, row_d;
  logic [NUM_COLS-1:0]  col_q, col_d;
  logic                 frame_q, frame_d;

  // Scan timebase: clock divider -> PWM slot -> row index
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    row_adv    = tick && (pwm_cnt_q == PWM_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + PIX_W'(1) : pwm_cnt_q;
    row_idx_d  = row_idx_q;
    if (row_adv) begin
      row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_W'(1);
    end
  end

  // Bus side: byte-lane writes into the bus-visible bank, registered read/ack
  always_comb begin
    req     = wb.i_wb_cyc && wb.i_wb_stb;
    wr_req  = req && wb.i_wb_we;
    rd_req  = req && !wb.i_wb_we;
    addr_ok = (32'(wb.i_wb_addr) < REG_COUNT);
    bank_d  = bank_q;
    if (wr_req && addr_ok) begin
      for (int unsigned b = 0; b < WB_SEL_WIDTH; b++) begin
        if (wb.i_wb_sel[b]) begin
          bank_d[wb.i_wb_addr][8*b +: 8] = wb.i_wb_wdata[8*b +: 8];
        end
      end
    end
    ack_d   = req;
    rdata_d = rdata_q;
    if (rd_req) begin
      rdata_d = addr_ok ? bank_q[wb.i_wb_addr] : '0;
    end
  end

`ifdef MATRIX_FB_DBUF_EN
  word_t front_q [REG_COUNT];
  word_t front_d [REG_COUNT];
  logic  dirty_q, dirty_d;
  logic  frame_end, swap;

  // Copy back to front only at frame end with the bus idle, so a frame never tears
  always_comb begin
    frame_end = row_adv && (row_idx_q == ROW_LAST);
    swap      = frame_end && dirty_q && !wb.i_wb_cyc;
    front_d   = front_q;
    dirty_d   = dirty_q;
    if (swap) begin
      front_d = bank_q;
      dirty_d = 1'b0;
    end
    if (wr_req) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        front_q[i] <= '0;
      end
      dirty_q <= 1'b0;
    end else begin
      front_q <= front_d;
      dirty_q <= dirty_d;
    end
  end

  assign disp_row = front_q[row_idx_q];
`else
  assign disp_row = bank_q[row_idx_q];
`endif

  // Column compare: slot 15 can never be lit, giving blanking before each row change
  always_comb begin
    row_d = REG_COUNT'(1) << row_idx_q;
    col_d = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      col_d[c] = (disp_row[PIX_W*c +: PIX_W] > pwm_cnt_q);
    end
    frame_d = (row_idx_q == '0) && !row_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      row_idx_q  <= '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        bank_q[i] <= '0;
      end
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      row_idx_q  <= row_idx_d;
      bank_q     <= bank_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      row_q      <= row_d;
      col_q      <= col_d;
      frame_q    <= frame_d;
    end
  end

  // Ack is qualified by cyc so an abandoned cycle never sees a stray ack
  assign wb.o_wb_ack   = ack_q && wb.i_wb_cyc;
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_rdata = rdata_q;
  assign o_row         = row_q;
  assign o_col         = col_q;
  assign o_frame       = frame_q;
endmodule

// File: tb/tb_matrix_fb_scan.sv
// Scoreboard bench for matrix_fb_scan: bus responses queued at the request edge,
// scan outputs compared every cycle against a closed-form timeline model.
module tb_matrix_fb_scan;
  localparam int CLK_DIV = 4;
  localparam int ROWP    = 16 * CLK_DIV;
  localparam int FRAMEP  = 8 * ROWP;

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] o_row;
  logic [7:0] o_col;
  logic       o_frame;

  matrix_fb_scan_if #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(3), .WB_SEL_WIDTH(4)) bus ();

  matrix_fb_scan #(
    .WB_DATA_WIDTH(32), .REG_COUNT(8), .WB_ADDR_WIDTH(3), .WB_SEL_WIDTH(4), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .wb(bus), .o_row(o_row), .o_col(o_col), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          scan_t = -1;
  sb_t         sb_q[$];
  logic [31:0] mem_m [8];
  logic [31:0] disp_prev [8];
  logic [31:0] last_rdata = '0;
`ifdef MATRIX_FB_DBUF_EN
  logic [31:0] front_m [8];
  logic        dirty_m;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: snoops requests at each edge, tracks time since reset release
  always @(posedge clk) begin
    if (reset) begin
      scan_t <= -1;
      for (int i = 0; i < 8; i++) mem_m[i] <= '0;
      sb_q.delete();
`ifdef MATRIX_FB_DBUF_EN
      for (int i = 0; i < 8; i++) front_m[i] <= '0;
      dirty_m <= 1'b0;
`endif
    end else begin
      scan_t <= scan_t + 1;
      if (bus.i_wb_cyc && bus.i_wb_stb) begin
        if (bus.i_wb_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.i_wb_sel[b]) mem_m[bus.i_wb_addr][8*b +: 8] <= bus.i_wb_wdata[8*b +: 8];
          sb_q.push_back('{rd: 1'b0, data: 32'h0});
`ifdef MATRIX_FB_DBUF_EN
          dirty_m <= 1'b1;
`endif
        end else begin
          sb_q.push_back('{rd: 1'b1, data: mem_m[bus.i_wb_addr]});
        end
      end
`ifdef MATRIX_FB_DBUF_EN
      if (((scan_t + 1) % FRAMEP) == FRAMEP - 1 && dirty_m && !bus.i_wb_cyc) begin
        front_m <= mem_m;
        dirty_m <= 1'b0;
      end
`endif
    end
`ifdef MATRIX_FB_DBUF_EN
    disp_prev <= front_m;
`else
    disp_prev <= mem_m;
`endif
  end

  // Response and scan checker
  always @(negedge clk) begin
    logic [7:0] e_row;
    logic [7:0] e_col;
    logic       e_frame;
    int         r;
    int         p;
    sb_t        e;
    check("stall", 32'(bus.o_wb_stall), 32'd0);
    if (bus.o_wb_ack) begin
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.rd) begin
          check("rdata", bus.o_wb_rdata, e.data);
          last_rdata = bus.o_wb_rdata;
        end
      end
    end
    e_row = '0;
    e_col = '0;
    e_frame = 1'b0;
    if (scan_t >= 0) begin
      r = (scan_t / ROWP) % 8;
      p = (scan_t / CLK_DIV) % 16;
      e_row = 8'(1) << r;
      for (int c = 0; c < 8; c++) e_col[c] = (disp_prev[r][4*c +: 4] > 4'(p));
      e_frame = ((scan_t % FRAMEP) == 0);
    end
    check("row", 32'(o_row), 32'(e_row));
    check("col", 32'(o_col), 32'(e_col));
    check("frame", 32'(o_frame), 32'(e_frame));
  end

  task automatic bus_set(input logic cyc, input logic stb, input logic we,
                         input logic [2:0] a, input logic [3:0] sel, input logic [31:0] d);
    bus.i_wb_cyc   = cyc;
    bus.i_wb_stb   = stb;
    bus.i_wb_we    = we;
    bus.i_wb_addr  = a;
    bus.i_wb_sel   = sel;
    bus.i_wb_wdata = d;
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (scan_t < target && n < 4 * FRAMEP) begin
      @(negedge clk);
      n++;
    end
    if (scan_t < target) check("wait_t_timeout", 32'(scan_t), 32'(target));
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    while (sb_q.size() != 0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic scan_window(input int n, output int frames, output int c7_r0, output int c0_r3);
    frames = 0;
    c7_r0  = 0;
    c0_r3  = 0;
    repeat (n) begin
      @(negedge clk);
      if (o_frame) frames++;
      if (o_row == 8'h01 && o_col[7]) c7_r0++;
      if (o_row == 8'h08 && o_col[0]) c0_r3++;
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, c7, c0;
    reset = 1'b1;
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_t(0);

    // Idle, dark picture, two frames
    scan_window(2 * FRAMEP, nf, c7, c0);
    check("idle_frames", 32'(nf), 32'd2);
    check("idle_c7", 32'(c7), 32'd0);

    // Single write, ack exactly one cycle later
    bus_set(1, 1, 1, 3'd0, 4'hF, 32'hF000_0000);
    @(negedge clk);
    check("ack_wr0", 32'(bus.o_wb_ack), 32'd1);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    @(negedge clk);
    check("ack_wr0_once", 32'(bus.o_wb_ack), 32'd0);
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_sb_empty();

    // Write then read back-to-back
    bus_set(1, 1, 1, 3'd3, 4'hF, 32'h0000_0008);
    @(negedge clk);
    check("ack_b2b_wr", 32'(bus.o_wb_ack), 32'd1);
    bus_set(1, 1, 0, 3'd3, 4'hF, 32'h0);
    @(negedge clk);
    check("ack_b2b_rd", 32'(bus.o_wb_ack), 32'd1);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    @(negedge clk);
    check("ack_b2b_end", 32'(bus.o_wb_ack), 32'd0);
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_sb_empty();
    check("rd_row3", last_rdata, 32'h0000_0008);

    // Partial byte-lane write
    bus_set(1, 1, 1, 3'd2, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_set(1, 1, 1, 3'd2, 4'b0010, 32'h0);
    @(negedge clk);
    bus_set(1, 1, 0, 3'd2, 4'hF, 32'h0);
    @(negedge clk);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    @(negedge clk);
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_sb_empty();
    check("rd_partial", last_rdata, 32'hFFFF_00FF);

    // Duty cycles over one full frame
    wait_t(scan_t + FRAMEP + 1);
    scan_window(FRAMEP, nf, c7, c0);
    check("frames_one", 32'(nf), 32'd1);
    check("duty_r0_c7", 32'(c7), 32'(15 * CLK_DIV));
    check("duty_r3_c0", 32'(c0), 32'(8 * CLK_DIV));

    // Master abandons the cycle right after the strobe
    bus_set(1, 1, 0, 3'd0, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    @(negedge clk);
    check("ack_cyc_drop", 32'(bus.o_wb_ack), 32'd0);
    @(negedge clk);
    check("ack_cyc_drop2", 32'(bus.o_wb_ack), 32'd0);
    sb_q.delete();

    // Reset while an ack is outstanding
    bus_set(1, 1, 0, 3'd2, 4'hF, 32'h0);
    @(negedge clk);
    check("ack_pending", 32'(bus.o_wb_ack), 32'd1);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ack", 32'(bus.o_wb_ack), 32'd0);
    check("rst_rdata", bus.o_wb_rdata, 32'd0);
    check("rst_row", 32'(o_row), 32'd0);
    check("rst_col", 32'(o_col), 32'd0);
    check("rst_frame", 32'(o_frame), 32'd0);
    reset = 1'b0;
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_t(0);

`ifdef MATRIX_FB_DBUF_EN
    // Mid-frame writes stay hidden until the frame-end swap
    wait_t(100);
    bus_set(1, 1, 1, 3'd7, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_set(1, 1, 1, 3'd0, 4'hF, 32'h1111_1111);
    @(negedge clk);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    @(negedge clk);
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_t(448);
    check("dbuf_hidden_r7", 32'(o_col), 32'd0);
    wait_t(512);
    check("dbuf_swapped_r0", 32'(o_col), 32'hFF);
    // Cycle held open across frame end defers the swap a full frame
    wait_t(700);
    bus_set(1, 1, 1, 3'd0, 4'hF, 32'h0);
    @(negedge clk);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_t(960);
    check("dbuf_r7_shown", 32'(o_col), 32'hFF);
    wait_t(1024);
    check("dbuf_deferred_r0", 32'(o_col), 32'hFF);
    wait_t(1030);
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_t(1472);
    check("dbuf_r7_kept", 32'(o_col), 32'hFF);
    wait_t(1536);
    check("dbuf_late_swap_r0", 32'(o_col), 32'h00);
`else
    // Write into the row being displayed shows up within two cycles
    wait_t(10);
    bus_set(1, 1, 1, 3'd0, 4'hF, 32'h0000_00F0);
    @(negedge clk);
    bus_set(1, 0, 0, 3'd0, 4'h0, 32'h0);
    @(negedge clk);
    bus_set(0, 0, 0, 3'd0, 4'h0, 32'h0);
    wait_t(20);
    check("collision_col", 32'(o_col), 32'h02);
`endif

    wait_t(scan_t + FRAMEP);
    wait_sb_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
